// File: rtl/router_pkg.sv
// Shared router constants: byte width, FIFO depth, port count and header field layout.
// Used by the FIFOs, synchroniser, FSM and register block.
package router_pkg;

  localparam int ROUTER_DATA_W     = 8;
  localparam int ROUTER_FIFO_DEPTH = 16;
  localparam int ROUTER_NUM_PORTS  = 3;

  // Header byte: [1:0] destination address, [7:2] payload length
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_ADDR_MSB = 1;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_MSB  = 7;

  typedef logic [ROUTER_DATA_W-1:0] router_byte_t;

  function automatic logic [HDR_LEN_MSB-HDR_LEN_LSB:0] hdr_len(input router_byte_t hdr);
    return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
  endfunction

endpackage

// File: rtl/router_fifo_if.sv
// Handshake bundle between the synchroniser/destination (master) and one packet FIFO (slave).
interface router_fifo_if #(
  parameter int DATA_W = 8
);

  logic              soft_reset;
  logic              write_enb;
  logic              lfd_state;
  logic [DATA_W-1:0] data_in;
  logic              read_enb;
  logic [DATA_W-1:0] data_out;
  logic              pkt_active;
  logic              full;
  logic              empty;

  modport master (
    output soft_reset, write_enb, lfd_state, data_in, read_enb,
    input  data_out, pkt_active, full, empty
  );

  modport slave (
    input  soft_reset, write_enb, lfd_state, data_in, read_enb,
    output data_out, pkt_active, full, empty
  );

endinterface

// File: rtl/router_fifo_mem.sv
// 1W1R storage for one packet FIFO: synchronous write, registered data read,
// plus a combinational peek of the word at the read address (tag + data).
module router_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W:0]   wr_word,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W:0]   rd_peek,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

  assign rd_peek = mem[rd_addr];

  // Output register clears on flush so a stale byte never looks valid downstream
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)     rd_data <= '0;
    else if (rd_clr) rd_data <= '0;
    else if (rd_en)  rd_data <= rd_peek[DATA_W-1:0];
  end

endmodule

// File: rtl/router_fifo.sv
// Per-destination packet FIFO: header-tagged storage, full/empty flags from
// wrap-bit pointers, and a read-side counter of bytes left in the current packet.
module router_fifo
  import router_pkg::*;
#(
  parameter int DATA_W = ROUTER_DATA_W,
  parameter int DEPTH  = ROUTER_FIFO_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH) + 1
) (
  input  logic           clock,
  input  logic           resetn,
  router_fifo_if.slave   fifo
);

  localparam int ADDR_W = PTR_W - 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [6:0]        pkt_count;
  logic [DATA_W:0]   rd_peek;
  logic              full_w;
  logic              empty_w;
  logic              do_wr;
  logic              do_rd;

  assign empty_w = (wr_ptr == rd_ptr);
  assign full_w  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  assign do_wr = fifo.write_enb & ~full_w & ~fifo.soft_reset;
  assign do_rd = fifo.read_enb  & ~empty_w & ~fifo.soft_reset;

  router_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock   (clock),
    .resetn  (resetn),
    .wr_en   (do_wr),
    .wr_addr (wr_ptr[ADDR_W-1:0]),
    .wr_word ({fifo.lfd_state, fifo.data_in}),
    .rd_en   (do_rd),
    .rd_clr  (fifo.soft_reset),
    .rd_addr (rd_ptr[ADDR_W-1:0]),
    .rd_peek (rd_peek),
    .rd_data (fifo.data_out)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_count <= '0;
    end else if (fifo.soft_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pkt_count <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        // A header always reloads: a new packet overrides any unfinished count
        if (rd_peek[DATA_W])
          pkt_count <= 7'(hdr_len(rd_peek[ROUTER_DATA_W-1:0])) + 7'd1;
        else if (pkt_count != 7'd0)
          pkt_count <= pkt_count - 7'd1;
      end
    end
  end

  assign fifo.full       = full_w;
  assign fifo.empty      = empty_w;
  assign fifo.pkt_active = (pkt_count != 7'd0);

endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo.
module tb_router_fifo;

  logic clock;
  logic resetn;
  int   pass_cnt;
  int   total_cnt;

  router_fifo_if #(.DATA_W(8)) bus ();

  router_fifo dut (
    .clock  (clock),
    .resetn (resetn),
    .fifo   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input logic lfd);
    bus.write_enb = 1'b1;
    bus.lfd_state = lfd;
    bus.data_in   = d;
    cyc();
    bus.write_enb = 1'b0;
    bus.lfd_state = 1'b0;
  endtask

  task automatic rd();
    bus.read_enb = 1'b1;
    cyc();
    bus.read_enb = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    #4;
    total_cnt++; if (bus.empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", bus.empty); else pass_cnt++;
    total_cnt++; if (bus.full !== 1'b0) $display("FAIL reset_full got=%b exp=0", bus.full); else pass_cnt++;
    total_cnt++; if (bus.pkt_active !== 1'b0) $display("FAIL reset_pkt_active got=%b exp=0", bus.pkt_active); else pass_cnt++;
    total_cnt++; if (bus.data_out !== 8'h00) $display("FAIL reset_data_out got=%h exp=00", bus.data_out); else pass_cnt++;
    cyc();
    resetn = 1'b1;
    cyc();
  endtask

  task automatic test_packet();
    logic [7:0] pkt [7] = '{8'h15, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h5C};
    int         cnt [7] = '{6, 5, 4, 3, 2, 1, 0};
    for (int i = 0; i < 7; i++) wr(pkt[i], i == 0);
    for (int i = 0; i < 7; i++) begin
      rd();
      total_cnt++; if (bus.data_out !== pkt[i]) $display("FAIL pkt_data[%0d] got=%h exp=%h", i, bus.data_out, pkt[i]); else pass_cnt++;
      total_cnt++; if (int'(dut.pkt_count) != cnt[i]) $display("FAIL pkt_count[%0d] got=%0d exp=%0d", i, dut.pkt_count, cnt[i]); else pass_cnt++;
      total_cnt++; if (bus.pkt_active !== (cnt[i] != 0)) $display("FAIL pkt_active[%0d] got=%b exp=%b", i, bus.pkt_active, cnt[i] != 0); else pass_cnt++;
    end
    total_cnt++; if (bus.empty !== 1'b1) $display("FAIL pkt_empty_after got=%b exp=1", bus.empty); else pass_cnt++;
  endtask

  task automatic test_full();
    logic [7:0] exp;
    do_reset();
    cyc();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        total_cnt++; if (bus.full !== 1'b0) $display("FAIL full_early got=%b exp=0", bus.full); else pass_cnt++;
      end
      wr(8'h30 + 8'(i), 1'b0);
    end
    total_cnt++; if (bus.full !== 1'b1) $display("FAIL full_after16 got=%b exp=1", bus.full); else pass_cnt++;
    wr(8'hFF, 1'b0);
    total_cnt++; if (dut.wr_ptr !== 5'd16) $display("FAIL full_drop_wrptr got=%0d exp=16", dut.wr_ptr); else pass_cnt++;
    for (int i = 0; i < 16; i++) begin
      rd();
      exp = 8'h30 + 8'(i);
      total_cnt++; if (bus.data_out !== exp) $display("FAIL full_data[%0d] got=%h exp=%h", i, bus.data_out, exp); else pass_cnt++;
    end
    total_cnt++; if (bus.empty !== 1'b1) $display("FAIL full_drain_empty got=%b exp=1", bus.empty); else pass_cnt++;
    total_cnt++; if (dut.wr_ptr !== 5'd16) $display("FAIL wrap_wr_ptr got=%0d exp=16", dut.wr_ptr); else pass_cnt++;
    total_cnt++; if (dut.rd_ptr !== 5'd16) $display("FAIL wrap_rd_ptr got=%0d exp=16", dut.rd_ptr); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 16; i++) wr(8'h40 + 8'(i), 1'b0);
    bus.write_enb = 1'b1;
    bus.read_enb  = 1'b1;
    bus.data_in   = 8'hEE;
    cyc();
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    total_cnt++; if (bus.full !== 1'b0) $display("FAIL sim_full_drop got=%b exp=0", bus.full); else pass_cnt++;
    total_cnt++; if (bus.data_out !== 8'h40) $display("FAIL sim_full_data got=%h exp=40", bus.data_out); else pass_cnt++;
    total_cnt++; if (dut.wr_ptr !== 5'd0) $display("FAIL sim_full_wrptr got=%0d exp=0", dut.wr_ptr); else pass_cnt++;
    for (int i = 0; i < 15; i++) rd();
    total_cnt++; if (bus.data_out !== 8'h4F) $display("FAIL sim_drain_last got=%h exp=4F", bus.data_out); else pass_cnt++;
    total_cnt++; if (bus.empty !== 1'b1) $display("FAIL sim_drain_empty got=%b exp=1", bus.empty); else pass_cnt++;
    bus.write_enb = 1'b1;
    bus.read_enb  = 1'b1;
    bus.data_in   = 8'h77;
    cyc();
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    total_cnt++; if (bus.empty !== 1'b0) $display("FAIL sim_empty_wr got=%b exp=0", bus.empty); else pass_cnt++;
    total_cnt++; if (bus.data_out !== 8'h4F) $display("FAIL sim_empty_nofall got=%h exp=4F", bus.data_out); else pass_cnt++;
    rd();
    total_cnt++; if (bus.data_out !== 8'h77) $display("FAIL sim_empty_retry got=%h exp=77", bus.data_out); else pass_cnt++;
  endtask

  task automatic test_soft_reset();
    wr(8'h18, 1'b1);
    for (int i = 0; i < 9; i++) wr(8'hB0 + 8'(i), 1'b0);
    for (int i = 0; i < 4; i++) rd();
    total_cnt++; if (dut.pkt_count !== 7'd4) $display("FAIL soft_pre_count got=%0d exp=4", dut.pkt_count); else pass_cnt++;
    bus.soft_reset = 1'b1;
    bus.write_enb  = 1'b1;
    bus.data_in    = 8'h99;
    cyc();
    bus.soft_reset = 1'b0;
    bus.write_enb  = 1'b0;
    total_cnt++; if (bus.empty !== 1'b1) $display("FAIL soft_empty got=%b exp=1", bus.empty); else pass_cnt++;
    total_cnt++; if (bus.full !== 1'b0) $display("FAIL soft_full got=%b exp=0", bus.full); else pass_cnt++;
    total_cnt++; if (dut.pkt_count !== 7'd0) $display("FAIL soft_count got=%0d exp=0", dut.pkt_count); else pass_cnt++;
    total_cnt++; if (bus.pkt_active !== 1'b0) $display("FAIL soft_pkt_active got=%b exp=0", bus.pkt_active); else pass_cnt++;
    total_cnt++; if (bus.data_out !== 8'h00) $display("FAIL soft_data_out got=%h exp=00", bus.data_out); else pass_cnt++;
    total_cnt++; if (dut.wr_ptr !== 5'd0) $display("FAIL soft_wr_discard got=%0d exp=0", dut.wr_ptr); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) wr(8'hC1 + 8'(i), 1'b0);
    rd();
    total_cnt++; if (bus.data_out !== 8'hC1) $display("FAIL async_pre_data got=%h exp=C1", bus.data_out); else pass_cnt++;
    #2;
    resetn = 1'b0;
    #1;
    total_cnt++; if (bus.empty !== 1'b1) $display("FAIL async_empty got=%b exp=1", bus.empty); else pass_cnt++;
    total_cnt++; if (bus.data_out !== 8'h00) $display("FAIL async_data_out got=%h exp=00", bus.data_out); else pass_cnt++;
    #2;
    resetn = 1'b1;
    cyc();
  endtask

  task automatic test_back_to_back();
    wr(8'h08, 1'b1);
    wr(8'h0C, 1'b1);
    rd();
    total_cnt++; if (dut.pkt_count !== 7'd3) $display("FAIL b2b_first_count got=%0d exp=3", dut.pkt_count); else pass_cnt++;
    rd();
    total_cnt++; if (dut.pkt_count !== 7'd4) $display("FAIL b2b_reload_count got=%0d exp=4", dut.pkt_count); else pass_cnt++;
    total_cnt++; if (bus.data_out !== 8'h0C) $display("FAIL b2b_data got=%h exp=0C", bus.data_out); else pass_cnt++;
    total_cnt++; if (bus.pkt_active !== 1'b1) $display("FAIL b2b_pkt_active got=%b exp=1", bus.pkt_active); else pass_cnt++;
  endtask

  initial begin
    pass_cnt       = 0;
    total_cnt      = 0;
    resetn         = 1'b0;
    bus.soft_reset = 1'b0;
    bus.write_enb  = 1'b0;
    bus.lfd_state  = 1'b0;
    bus.data_in    = 8'h00;
    bus.read_enb   = 1'b0;
    test_reset();
    test_packet();
    test_full();
    test_simultaneous();
    test_soft_reset();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/router_fifo.md
Name: router_fifo

Overview:
- One of three identical per-destination packet FIFOs in the 1x3 router.
- Sits directly downstream of the synchroniser, which drives one bit of its 3-bit write_enb into each FIFO's write_enb.
- Returns full (the synchroniser muxes it into fifo_full) and empty (inverted into vld_out_x).
- Stores header/payload/parity bytes with a header tag, tracks the packet length on the read side, and is flushed by the synchroniser's soft_reset_x timeout.

Parameters:
- DATA_W, 8, byte width of data_in/data_out.
- DEPTH, 16, number of entries; must be a power of 2.
- PTR_W, 5, log2(DEPTH)+1; the extra MSB is the wrap bit.

Ports:
- clock  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- soft_reset  in  1  synchronous flush, driven by soft_reset_x of the synchroniser.
- write_enb  in  1  write request, one bit of the synchroniser's write_enb.
- lfd_state  in  1  high in the same cycle as write_enb when the byte written is the header.
- data_in  in  DATA_W  byte to write.
- read_enb  in  1  read request from the destination.
- data_out  out  DATA_W  registered read data.
- pkt_active  out  1  high while bytes of the current packet remain to be read after the header.
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.

Behaviour:
- Reset is asynchronous and active-low: clock and resetn, resetn asynchronous, active-low.
- On resetn low: wr_ptr=0, rd_ptr=0, pkt_count=0, data_out=0, so empty=1, full=0, pkt_active=0.
- Storage: DEPTH entries of DATA_W+1 bits. Bit DATA_W holds the lfd_state tag captured at write time.
- full and empty are combinational from the pointers:
  - empty = (wr_ptr == rd_ptr).
  - full = pointer MSBs differ and the lower PTR_W-1 bits are equal.
- Write (do_wr = write_enb & ~full):
  - at the clock edge, mem[wr_ptr[PTR_W-2:0]] <= {lfd_state, data_in}; wr_ptr++.
  - A write while full is dropped silently; the upstream stalls on fifo_full.
- Read (do_rd = read_enb & ~empty):
  - at the clock edge, data_out <= mem[rd_ptr][DATA_W-1:0]; rd_ptr++.
  - Data appears one cycle after the accepted read_enb.
  - data_out holds its value when there is no accepted read.
  - A read while empty is ignored: no pointer change, data_out held.
- Simultaneous do_wr and do_rd: both occur; occupancy is unchanged.
  - When full, only the read is accepted.
  - When empty, only the write is accepted; there is no fall-through, so the read must be retried next cycle.
- Wrap-around: pointers wrap naturally modulo 2*DEPTH; the low bits index memory.
- Packet counter pkt_count (7 bits):
  - On do_rd of a tagged (header) entry: pkt_count <= data[7:2] + 1, i.e. payload length plus the parity byte (range 1..64).
  - On do_rd of an untagged entry with pkt_count > 0: pkt_count--.
  - An untagged read with pkt_count == 0 leaves it at 0 (stray byte; data is still delivered).
  - A header read while pkt_count > 0 reloads the counter; the new packet wins.
- pkt_active = (pkt_count != 0).
- soft_reset (synchronous, highest priority over read/write in the same cycle):
  - wr_ptr=0, rd_ptr=0, pkt_count=0, data_out=0.
  - The write or read in that cycle is discarded.
  - The memory contents need not be cleared.
- resetn asserted mid-packet: immediate return to reset values; no partial state survives.

Decomposition:
- Package router_pkg:
  - ROUTER_DATA_W=8, ROUTER_FIFO_DEPTH=16.
  - Header field constants HDR_ADDR_LSB=0/HDR_ADDR_MSB=1 and HDR_LEN_LSB=2/HDR_LEN_MSB=7.
  - ROUTER_NUM_PORTS=3.
  - These are shared with the synchroniser, the FSM and the register block.
- Optional sub-module router_fifo_mem: a 1W1R synchronous array, write port plus registered read port.
- Pointer, flag and counter logic stay in router_fifo.

Test Plan:
- Reset, then write header 8'h15 (len 5, addr 1, lfd_state=1), five payload bytes 8'hA0..8'hA4, and parity 8'h5C. Read all 7 -> data_out in order one cycle after each read_enb. pkt_count shows 6 after the header, reaches 0 after the parity read, and pkt_active falls with it. empty returns to 1.
- Write 16 bytes with read_enb=0 -> full=1 after the 16th write. A 17th write is dropped; reading 16 bytes returns the first 16 exactly. Then empty=1 with both pointers at 16 (wrap bit set).
- At full, assert write_enb and read_enb together -> only the read is accepted and full drops to 0. At empty, assert both -> only the write is accepted and empty drops to 0.
- Fill 10 bytes mid-packet (pkt_count=4), then pulse soft_reset together with write_enb -> next cycle empty=1, full=0, pkt_count=0, data_out=0, and the concurrent write is discarded.
- Assert resetn=0 asynchronously between clock edges with 5 entries stored -> empty=1 and data_out=0 immediately, without waiting for a clock edge.
- Write header 8'h08 (len 2), then a second header 8'h0C (len 3) before the first packet completes. Read both headers back to back -> pkt_count reloads to 4 on the second header read.
